// File: rtl/serial_mag_comparator.sv
`default_nettype none
// ============================================================================
// Module      : serial_mag_comparator
// Description : Unsigned magnitude comparator consuming two bits per clock,
//               MSB digit first, with optional early exit on first difference.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_mag_comparator #(
  parameter int WIDTH      = 8,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic [WIDTH-1:0]                 a,
  input  logic [WIDTH-1:0]                 b,
  output logic                             busy,
  output logic                             done,
  output logic                             eq,
  output logic                             gt,
  output logic                             lt,
  output logic [$clog2(WIDTH/2+1)-1:0]     digits_used
);

  localparam int              c_digits   = WIDTH / 2;
  localparam int              c_cw       = $clog2(c_digits + 1);
  localparam logic [c_cw-1:0] c_one      = c_cw'(1);
  localparam logic [c_cw-1:0] c_cnt_init = c_cw'(c_digits);

  typedef enum logic [0:0] {
    S_IDLE    = 1'b0,
    S_COMPARE = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [WIDTH-1:0]  r_sa;
  logic [WIDTH-1:0]  r_sb;
  logic              r_e;
  logic              r_g;
  logic [c_cw-1:0]   r_cnt;
  logic [c_cw-1:0]   r_used;
  logic              r_done;
  logic              r_eq;
  logic              r_gt;
  logic              r_lt;

  logic [1:0]        w_da;
  logic [1:0]        w_db;
  logic              w_e_next;
  logic              w_g_next;
  logic              w_last;
  logic              w_stop;
  logic              w_accept;

  assign w_da     = r_sa[WIDTH-1 -: 2];
  assign w_db     = r_sb[WIDTH-1 -: 2];
  assign w_last   = (r_cnt == c_one);
  assign w_accept = (r_state == S_IDLE) && start;

  // Once the chain has left the equal state the earlier decision is final.
  always_comb begin
    w_e_next = r_e;
    w_g_next = r_g;
    if (r_e) begin
      if (w_da == w_db) begin
        w_e_next = 1'b1;
        w_g_next = 1'b0;
      end else if (w_da > w_db) begin
        w_e_next = 1'b0;
        w_g_next = 1'b1;
      end else begin
        w_e_next = 1'b0;
        w_g_next = 1'b0;
      end
    end
  end

  generate
    if (EARLY_EXIT) begin : g_early_exit
      assign w_stop = w_last | ~w_e_next;
    end else begin : g_full_scan
      assign w_stop = w_last;
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:    if (start)  w_state_next = S_COMPARE;
      S_COMPARE: if (w_stop) w_state_next = S_IDLE;
      default:               w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sa   <= '0;
      r_sb   <= '0;
      r_e    <= 1'b0;
      r_g    <= 1'b0;
      r_cnt  <= '0;
      r_used <= '0;
      r_done <= 1'b0;
      r_eq   <= 1'b0;
      r_gt   <= 1'b0;
      r_lt   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_sa   <= a;
        r_sb   <= b;
        r_e    <= 1'b1;
        r_g    <= 1'b0;
        r_cnt  <= c_cnt_init;
        r_used <= '0;
        r_eq   <= 1'b0;
        r_gt   <= 1'b0;
        r_lt   <= 1'b0;
      end else if (r_state == S_COMPARE) begin
        r_sa   <= r_sa << 2;
        r_sb   <= r_sb << 2;
        r_cnt  <= r_cnt - c_one;
        r_used <= r_used + c_one;
        r_e    <= w_e_next;
        r_g    <= w_g_next;
        if (w_stop) begin
          r_eq   <= w_e_next;
          r_gt   <= ~w_e_next & w_g_next;
          r_lt   <= ~w_e_next & ~w_g_next;
          r_done <= 1'b1;
        end
      end
    end
  end

  assign busy        = (r_state == S_COMPARE);
  assign done        = r_done;
  assign eq          = r_eq;
  assign gt          = r_gt;
  assign lt          = r_lt;
  assign digits_used = r_used;

endmodule
`default_nettype wire
